regfile_2w2r_sb: RTL and testbench

//   Parametrised register file: 2 async read ports, 2 sync write ports, write-to-read bypass,

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rf_scoreboard.sv | 53 +++++
 rtl/regfile_2w2r_sb.sv | 84 ++++++++
 tb/tb_regfile_2w2r_sb.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and helpers for the two-write/two-read register file with busy scoreboard.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 2;
  localparam int ZERO_IDX   = 0;

  function automatic int depth(input int aw);
    return 1 << aw;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: set on reserve, cleared on writeback, wiped by flush.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Flush,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveReg,
  input  logic              WrEnA,
  input  logic [ADDR_W-1:0] WrRegA,
  input  logic              WrEnB,
  input  logic [ADDR_W-1:0] WrRegB,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic              Busy1,
  output logic              Busy2
);

  localparam int DEPTH = depth(ADDR_W);

  logic [DEPTH-1:0] busy;
  logic [DEPTH-1:0] busyNext;
  logic             reserveOk;

  // The zero register never has a producer, so reserving it is a no-op.
  assign reserveOk = Reserve && !(ZERO_REG && (ReserveReg == ADDR_W'(ZERO_IDX)));

  always_comb begin
    busyNext = busy;
    for (int r = 0; r < DEPTH; r++) begin
      if (Flush)
        busyNext[r] = 1'b0;
      else if (reserveOk && (ReserveReg == ADDR_W'(r)))
        busyNext[r] = 1'b1;
      else if ((WrEnA && (WrRegA == ADDR_W'(r))) || (WrEnB && (WrRegB == ADDR_W'(r))))
        busyNext[r] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) busy <= '0;
    else        busy <= busyNext;
  end

  // Data arriving this cycle is bypassed to the reader, so it is not reported busy.
  assign Busy1 = busy[ReadReg1] & ~((WrEnA && (WrRegA == ReadReg1)) || (WrEnB && (WrRegB == ReadReg1)));
  assign Busy2 = busy[ReadReg2] & ~((WrEnA && (WrRegA == ReadReg2)) || (WrEnB && (WrRegB == ReadReg2)));

endmodule

// File: rtl/regfile_2w2r_sb.sv
// Register file: 2 async read ports with write bypass, 2 sync write ports (B has priority),
// optional hardwired zero register and a busy scoreboard for issue/writeback tracking.
module regfile_2w2r_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              RegWriteA,
  input  logic [ADDR_W-1:0] WriteRegA,
  input  logic [DATA_W-1:0] WriteDataA,
  input  logic              RegWriteB,
  input  logic [ADDR_W-1:0] WriteRegB,
  input  logic [DATA_W-1:0] WriteDataB,
  input  logic              Reserve,
  input  logic [ADDR_W-1:0] ReserveReg,
  input  logic              Flush
);

  localparam int DEPTH = depth(ADDR_W);

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wrEnA;
  logic              wrEnB;
  logic              wrStoreA;

  // Writes aimed at the hardwired zero register are dropped before they reach anything.
  assign wrEnA = RegWriteA && !(ZERO_REG && (WriteRegA == ADDR_W'(ZERO_IDX)));
  assign wrEnB = RegWriteB && !(ZERO_REG && (WriteRegB == ADDR_W'(ZERO_IDX)));
  assign wrStoreA = wrEnA && !(wrEnB && (WriteRegA == WriteRegB));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (wrStoreA) regs[WriteRegA] <= WriteDataA;
      if (wrEnB)    regs[WriteRegB] <= WriteDataB;
    end
  end

  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] addr);
    if (wrEnB && (WriteRegB == addr))      return WriteDataB;
    else if (wrEnA && (WriteRegA == addr)) return WriteDataA;
    else                                   return regs[addr];
  endfunction

  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    if (reset) begin
      ReadData1 = readPort(ReadReg1);
      ReadData2 = readPort(ReadReg2);
    end
  end

  rf_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .Flush     (Flush),
    .Reserve   (Reserve),
    .ReserveReg(ReserveReg),
    .WrEnA     (wrEnA),
    .WrRegA    (WriteRegA),
    .WrEnB     (wrEnB),
    .WrRegB    (WriteRegB),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .Busy1     (Busy1),
    .Busy2     (Busy2)
  );

endmodule

// File: tb/tb_regfile_2w2r_sb.sv
// Directed bench for regfile_2w2r_sb: a ZERO_REG=1 and a ZERO_REG=0 instance share all inputs.
module tb_regfile_2w2r_sb;

  localparam int DW = 32;
  localparam int AW = 2;
  localparam int EW = 4 * DW + 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] ReadReg1, ReadReg2, WriteRegA, WriteRegB, ReserveReg;
  logic [DW-1:0] WriteDataA, WriteDataB;
  logic          RegWriteA, RegWriteB, Reserve, Flush;

  logic [DW-1:0] rd1Z, rd2Z, rd1N, rd2N;
  logic          b1Z, b2Z, b1N, b2N;

  logic [EW-1:0] exp_q[$];
  string         name_q[$];
  int            passCount = 0;
  int            totalCount = 0;

  always #5 clk = ~clk;

  regfile_2w2r_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b1)) dutZ (
    .clk(clk), .reset(reset),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1Z), .ReadData2(rd2Z), .Busy1(b1Z), .Busy2(b2Z),
    .RegWriteA(RegWriteA), .WriteRegA(WriteRegA), .WriteDataA(WriteDataA),
    .RegWriteB(RegWriteB), .WriteRegB(WriteRegB), .WriteDataB(WriteDataB),
    .Reserve(Reserve), .ReserveReg(ReserveReg), .Flush(Flush)
  );

  regfile_2w2r_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1'b0)) dutN (
    .clk(clk), .reset(reset),
    .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
    .ReadData1(rd1N), .ReadData2(rd2N), .Busy1(b1N), .Busy2(b2N),
    .RegWriteA(RegWriteA), .WriteRegA(WriteRegA), .WriteDataA(WriteDataA),
    .RegWriteB(RegWriteB), .WriteRegB(WriteRegB), .WriteDataB(WriteDataB),
    .Reserve(Reserve), .ReserveReg(ReserveReg), .Flush(Flush)
  );

  // Driver tasks
  task automatic drive(input logic rwA, input logic [AW-1:0] wA, input logic [DW-1:0] dA,
                       input logic rwB, input logic [AW-1:0] wB, input logic [DW-1:0] dB,
                       input logic rsv, input logic [AW-1:0] rr, input logic fl,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    RegWriteA = rwA; WriteRegA = wA; WriteDataA = dA;
    RegWriteB = rwB; WriteRegB = wB; WriteDataB = dB;
    Reserve = rsv; ReserveReg = rr; Flush = fl;
    ReadReg1 = r1; ReadReg2 = r2;
  endtask

  task automatic idle(input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0, r1, r2);
  endtask

  task automatic expect_out(input string nm,
                            input logic [DW-1:0] e1z, input logic [DW-1:0] e2z,
                            input logic eb1z, input logic eb2z,
                            input logic [DW-1:0] e1n, input logic [DW-1:0] e2n,
                            input logic eb1n, input logic eb2n);
    exp_q.push_back({e1z, e2z, eb1z, eb2z, e1n, e2n, eb1n, eb2n});
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: outputs are combinational, so every queued expectation
  // is checked at the falling edge following the cycle it was issued in.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      logic [EW-1:0] got;
      string         nm;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      got = {rd1Z, rd2Z, b1Z, b2Z, rd1N, rd2N, b1N, b2N};
      totalCount++;
      if (got === e) passCount++;
      else $display("FAIL %s: got %h expected %h", nm, got, e);
    end
  end

  initial begin
    reset = 1'b0;
    idle(2'd0, 2'd0);
    tick();

    // Writes during reset are ignored and outputs read zero.
    drive(1'b1, 2'd2, 32'hAAAAFFFF, 1'b0, '0, '0, 1'b0, '0, 1'b0, 2'd2, 2'd0);
    expect_out("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    idle(2'd2, 2'd0);
    expect_out("reset_write_dropped", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(1'b1, 2'd2, 32'hAAAAFFFF, 1'b0, '0, '0, 1'b0, '0, 1'b0, 2'd2, 2'd0);
    expect_out("bypass_a", 32'hAAAAFFFF, 0, 0, 0, 32'hAAAAFFFF, 0, 0, 0);
    tick();
    idle(2'd2, 2'd0);
    expect_out("array_r2", 32'hAAAAFFFF, 0, 0, 0, 32'hAAAAFFFF, 0, 0, 0);
    tick();

    // Same-address dual write: B wins in bypass and in the array.
    drive(1'b1, 2'd1, 32'h11111111, 1'b1, 2'd1, 32'h22222222, 1'b0, '0, 1'b0, 2'd1, 2'd1);
    expect_out("ab_bypass", 32'h22222222, 32'h22222222, 0, 0, 32'h22222222, 32'h22222222, 0, 0);
    tick();
    idle(2'd1, 2'd2);
    expect_out("ab_array", 32'h22222222, 32'hAAAAFFFF, 0, 0, 32'h22222222, 32'hAAAAFFFF, 0, 0);
    tick();

    // Reserve r3, then writeback with same-cycle read: bypassed data is not busy.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 2'd3, 1'b0, 2'd3, 2'd3);
    expect_out("reserve_r3_pre", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    idle(2'd3, 2'd3);
    expect_out("r3_busy", 0, 0, 1, 1, 0, 0, 1, 1);
    tick();
    drive(1'b1, 2'd3, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, '0, 1'b0, 2'd3, 2'd3);
    expect_out("bypass_r3", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    tick();
    idle(2'd3, 2'd3);
    expect_out("r3_cleared", 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0);
    tick();

    // Register 0: hardwired in dutZ, ordinary in dutN.
    drive(1'b1, 2'd0, 32'hFFFFFFFF, 1'b0, '0, '0, 1'b1, 2'd0, 1'b0, 2'd0, 2'd0);
    expect_out("r0_write", 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    tick();
    idle(2'd0, 2'd0);
    expect_out("r0_after", 0, 0, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1);
    tick();

    // Reserve and write of r2 in the same cycle leave it busy.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 2'd2, 1'b0, 2'd2, 2'd0);
    expect_out("reserve_r2_pre", 32'hAAAAFFFF, 0, 0, 0, 32'hAAAAFFFF, 32'hFFFFFFFF, 0, 1);
    tick();
    drive(1'b1, 2'd2, 32'h5, 1'b0, '0, '0, 1'b1, 2'd2, 1'b0, 2'd2, 2'd0);
    expect_out("reserve_write_r2", 32'h5, 0, 0, 0, 32'h5, 32'hFFFFFFFF, 0, 1);
    tick();
    idle(2'd2, 2'd0);
    expect_out("r2_still_busy", 32'h5, 0, 1, 0, 32'h5, 32'hFFFFFFFF, 1, 1);
    tick();
    drive(1'b0, '0, '0, 1'b1, 2'd2, 32'h6, 1'b0, '0, 1'b0, 2'd2, 2'd0);
    expect_out("write_b_r2", 32'h6, 0, 0, 0, 32'h6, 32'hFFFFFFFF, 0, 1);
    tick();
    idle(2'd2, 2'd0);
    expect_out("r2_cleared", 32'h6, 0, 0, 0, 32'h6, 32'hFFFFFFFF, 0, 1);
    tick();

    // Flush clears every busy bit and beats a same-cycle reserve.
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 2'd1, 1'b0, 2'd1, 2'd3);
    expect_out("reserve_r1", 32'h22222222, 32'hDEADBEEF, 0, 0, 32'h22222222, 32'hDEADBEEF, 0, 0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 2'd3, 1'b0, 2'd1, 2'd3);
    expect_out("reserve_r3", 32'h22222222, 32'hDEADBEEF, 1, 0, 32'h22222222, 32'hDEADBEEF, 1, 0);
    tick();
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 2'd2, 1'b1, 2'd1, 2'd3);
    expect_out("flush_cycle", 32'h22222222, 32'hDEADBEEF, 1, 1, 32'h22222222, 32'hDEADBEEF, 1, 1);
    tick();
    idle(2'd1, 2'd2);
    expect_out("after_flush", 32'h22222222, 32'h6, 0, 0, 32'h22222222, 32'h6, 0, 0);
    tick();
    idle(2'd0, 2'd2);
    expect_out("after_flush_r0", 0, 32'h6, 0, 0, 32'hFFFFFFFF, 32'h6, 0, 0);
    tick();

    // Asynchronous reset clears state before the next rising edge.
    reset = 1'b0;
    idle(2'd1, 2'd0);
    expect_out("async_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    idle(2'd1, 2'd0);
    expect_out("post_reset", 0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      totalCount++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
